// File: rtl/proc_run_pkg.sv
// proc_run_pkg: shared state encoding and default end-of-program PC for proc_run_ctrl.
package proc_run_pkg;
    typedef enum logic [2:0] {RST_HOLD, PC_HOLD, RUN, DRAIN, DONE} run_state_t;
    localparam logic [31:0] END_PC_DEFAULT = 32'h8008_8008;
endpackage

// File: rtl/proc_run_ctrl_stall_seq.sv
// stall_seq: issue/stall sequencer, one issue cycle followed by STALL_CYCLES stalls; restart forces an issue.
module stall_seq #(
    parameter int STALL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic stall
);
    logic [31:0] scount;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scount <= '0;
            stall  <= 1'b0;
        end else if (!en || restart || scount == 32'(STALL_CYCLES)) begin
            scount <= '0;
            stall  <= 1'b0;
        end else begin
            scount <= scount + 32'd1;
            stall  <= 1'b1;
        end
    end
endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: reset release, stall pattern, end-of-program drain and done flag for the MIPS pipeline.
// Build with PROC_RUN_TIMEOUT_EN to add a watchdog that forces DONE with timeout after TIMEOUT_CYCLES.
module proc_run_ctrl import proc_run_pkg::*; #(
    parameter int          RST_HOLD       = 1,
    parameter int          PC_RST_HOLD    = 1,
    parameter int          STALL_CYCLES   = 4,
    parameter logic [31:0] END_PC         = END_PC_DEFAULT,
    parameter int          DRAIN_CYCLES   = 2,
    parameter int          CNT_W          = 32,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      next_pc,
    input  logic             jbr_taken,
    output logic             core_rst,
    output logic             pc_rst,
    output logic             stall,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);
    run_state_t  state, state_next;
    logic [31:0] cnt, cnt_next;
    logic        core_rst_next, pc_rst_next, done_next, in_run, end_hit, wd_hit;

    assign in_run  = state == RUN;
    assign end_hit = in_run && next_pc == END_PC;

`ifdef PROC_RUN_TIMEOUT_EN
    assign wd_hit = in_run && cycle_count >= CNT_W'(TIMEOUT_CYCLES);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout <= 1'b0;
        else     timeout <= timeout | (wd_hit && !end_hit);
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    stall_seq #(.STALL_CYCLES(STALL_CYCLES)) u_stall_seq (
        .clk     (clk),
        .rst     (rst),
        .en      (in_run),
        .restart (jbr_taken | end_hit),
        .stall   (stall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= proc_run_pkg::RST_HOLD;
            cnt         <= '0;
            core_rst    <= 1'b1;
            pc_rst      <= 1'b1;
            done        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            core_rst    <= core_rst_next;
            pc_rst      <= pc_rst_next;
            done        <= done_next;
            cycle_count <= (in_run || state == DRAIN) && cycle_count != '1 ? cycle_count + 1'b1 : cycle_count;
        end
    end

    // end_hit outranks the watchdog so a program finishing on the limit still drains
    always_comb begin
        state_next = state;
        case (state)
            proc_run_pkg::RST_HOLD: state_next = cnt == 32'(RST_HOLD - 1) ? PC_HOLD : state;
            PC_HOLD:                state_next = cnt == 32'(PC_RST_HOLD - 1) ? RUN : state;
            RUN:                    state_next = end_hit ? DRAIN : wd_hit ? DONE : RUN;
            DRAIN:                  state_next = cnt == 32'(DRAIN_CYCLES - 1) ? DONE : state;
            default:                state_next = DONE;
        endcase
    end

    always_comb begin
        cnt_next      = (state_next != state || in_run || state == DONE) ? '0 : cnt + 32'd1;
        core_rst_next = state_next == proc_run_pkg::RST_HOLD;
        pc_rst_next   = state_next == proc_run_pkg::RST_HOLD || state_next == PC_HOLD;
        done_next     = state_next == DONE;
    end
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: scoreboarded directed test of reset release, stall pattern, branch cut, drain/done and mid-drain reset.
module tb_proc_run_ctrl;
    localparam logic [31:0] END = 32'h8008_8008;

    typedef struct {
        logic        cr, pr, st, dn, to;
        logic [31:0] cc;
        string       tag;
    } exp_t;

    logic        clk = 1'b1, rst = 1'b1, jbr_taken = 1'b0;
    logic [31:0] next_pc = '0;
    logic        core_rst, pc_rst, stall, done, timeout;
    logic [31:0] cycle_count;
    exp_t        q[$];
    int          n_cmp = 0, n_bad = 0;

    proc_run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .next_pc     (next_pc),
        .jbr_taken   (jbr_taken),
        .core_rst    (core_rst),
        .pc_rst      (pc_rst),
        .stall       (stall),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input exp_t e);
        n_cmp++;
        if ({core_rst, pc_rst, stall, done, timeout, cycle_count} !== {e.cr, e.pr, e.st, e.dn, e.to, e.cc}) begin
            n_bad++;
            $display("FAIL %s: got cr=%b pr=%b st=%b dn=%b to=%b cc=%0d, want cr=%b pr=%b st=%b dn=%b to=%b cc=%0d",
                     e.tag, core_rst, pc_rst, stall, done, timeout, cycle_count,
                     e.cr, e.pr, e.st, e.dn, e.to, e.cc);
        end
    endtask

    task automatic reset_chk(input string tag);
        exp_t e;
        e.cr = 1; e.pr = 1; e.st = 0; e.dn = 0; e.to = 0; e.cc = 0; e.tag = tag;
        chk(e);
    endtask

    // called at a negedge: drive inputs, queue the outputs expected after the next posedge
    task automatic step(input logic [31:0] pc, input logic j, input logic cr, input logic pr,
                        input logic st, input logic dn, input logic [31:0] cc, input string tag);
        exp_t e;
        next_pc = pc; jbr_taken = j;
        e.cr = cr; e.pr = pr; e.st = st; e.dn = dn; e.to = 0; e.cc = cc; e.tag = tag;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_steps(input int n);
        for (int k = 1; k <= n; k++)
            step(32'h400 + 32'(k * 4), 1'b0, 0, 0, (k % 5) != 0, 0, 32'(k), $sformatf("run%0d", k));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e);
            end
        end
    end

    initial begin : stim
        #12 reset_chk("reset_init");
        #3 rst = 1'b0;
        step(32'h100, 0, 0, 1, 0, 0, 0, "release_core");
        step(32'h104, 0, 0, 0, 0, 0, 0, "release_pc");
        run_steps(20);
        step(32'h500, 0, 0, 0, 1, 0, 21, "stall1");
        step(32'h504, 0, 0, 0, 1, 0, 22, "stall2");
        step(32'h508, 1, 0, 0, 0, 0, 23, "branch_cut");
        for (int k = 24; k <= 27; k++)
            step(32'h600, 0, 0, 0, 1, 0, 32'(k), $sformatf("after_cut%0d", k));
        step(32'h604, 0, 0, 0, 0, 0, 28, "issue_again");
        step(END, 1, 0, 0, 0, 0, 29, "end_seen");
        step(32'h700, 1, 0, 0, 0, 0, 30, "drain");
        step(32'h704, 0, 0, 0, 0, 1, 31, "done_set");
        step(END, 1, 0, 0, 0, 1, 31, "done_hold1");
        step(32'h0, 1, 0, 0, 0, 1, 31, "done_hold2");
        step(32'h10, 0, 0, 0, 0, 1, 31, "done_hold3");
        #2 rst = 1'b1;
        #1 reset_chk("reset_from_done");
        @(negedge clk);
        rst = 1'b0;
        step(32'h100, 0, 0, 1, 0, 0, 0, "rerelease_core");
        step(32'h104, 0, 0, 0, 0, 0, 0, "rerelease_pc");
        run_steps(60);
        step(END, 0, 0, 0, 0, 0, 61, "end2_seen");
        step(32'h0, 0, 0, 0, 0, 0, 62, "drain2");
        #2 rst = 1'b1;
        #1 reset_chk("reset_mid_drain");
        @(negedge clk);
        rst = 1'b0;
        step(32'h100, 0, 0, 1, 0, 0, 0, "third_release_core");
        step(32'h104, 0, 0, 0, 0, 0, 0, "third_release_pc");
        run_steps(6);
        #20;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
Parametrised run controller for the MIPS pipeline bench and FPGA harness. It generates the two-phase reset release (core reset, then PC reset) and a configurable multi-cycle stall pattern that a branch or jump can cut short. It also detects end-of-program on a sentinel next-PC, lets the pipeline drain, and raises a sticky done flag. It sits beside proc_top, driving its rst/pc_rst/stall inputs and observing next_pc/jbr_taken.

Parameters:
RST_HOLD, 1, clocks core_rst stays high after rst is released (min 1)
PC_RST_HOLD, 1, further clocks pc_rst stays high after core_rst falls (min 1)
STALL_CYCLES, 4, stall cycles between issue cycles; 0 = fully pipelined, stall never asserted
END_PC, 32'h80088008, next_pc value that signals end of program
DRAIN_CYCLES, 2, clocks spent in DRAIN before done
CNT_W, 32, width of cycle_count
TIMEOUT_CYCLES, 100000, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
next_pc  in  32  next fetch PC from the core
jbr_taken  in  1  jump/branch taken this cycle
core_rst  out  1  reset to the processor core
pc_rst  out  1  reset to the PC register
stall  out  1  pipeline stall
done  out  1  sticky program-complete flag
timeout  out  1  sticky watchdog flag
cycle_count  out  CNT_W  clocks spent in RUN+DRAIN, saturating

Behaviour:
- All outputs registered. On rst (async): state=RST_HOLD, core_rst=1, pc_rst=1, stall=0, done=0, timeout=0, cycle_count=0, stall counter=0, hold counter=0.
- States: RST_HOLD, PC_HOLD, RUN, DRAIN, DONE.
- RST_HOLD: hold counter increments each posedge. At the RST_HOLD-th edge after rst falls: core_rst<=0, counter cleared, go to PC_HOLD.
- PC_HOLD: at the PC_RST_HOLD-th edge: pc_rst<=0, go to RUN with stall=0 and scount=0.
- RUN stall sequencer, per edge:
  - if jbr_taken or scount==STALL_CYCLES: scount<=0, stall<=0.
  - else: scount<=scount+1, stall<=1.
  - Result with STALL_CYCLES=N: period N+1, one issue cycle followed by N stalled cycles.
  - jbr_taken restarts the period; its next cycle is an issue cycle.
- End detection (RUN only): next_pc==END_PC goes to DRAIN, stall<=0, scount<=0. This takes priority over jbr_taken in the same cycle.
- DRAIN: stall held 0 and a drain counter runs. After DRAIN_CYCLES edges: done<=1, go to DONE.
- DONE: terminal. done stays 1, stall 0, core_rst/pc_rst 0, cycle_count frozen. next_pc and jbr_taken are ignored. Only rst exits.
- cycle_count: +1 per edge in RUN and DRAIN. Saturates at all-ones, no wrap.
- next_pc and jbr_taken are ignored outside RUN (except as stated above).
- rst asserted mid-RUN or mid-DRAIN: immediate return to reset values; the sequence restarts on release.
- STALL_CYCLES=0: stall is constantly 0 in RUN.

Optional Feature:
Macro PROC_RUN_TIMEOUT_EN.
- Defined: a watchdog compares cycle_count with TIMEOUT_CYCLES in RUN. On reaching it, go directly to DONE with timeout<=1 and done<=1, skipping DRAIN.
- Undefined: no watchdog logic is built, and timeout is tied to 0.

Decomposition:
- Package proc_run_pkg: state enum run_state_t {RST_HOLD, PC_HOLD, RUN, DRAIN, DONE} and the default END_PC constant.
- Sub-module stall_seq holds the scount/stall generator, with enable (state==RUN), restart (jbr_taken | end) and STALL_CYCLES parameter. The FSM, hold/drain counters and cycle counter stay in the top module.

Test Plan:
- Reset release: rst high 15 ns, then low, defaults -> core_rst falls on the 1st edge after release, pc_rst on the 2nd; all other outputs 0 until then.
- Stall pattern: STALL_CYCLES=4, no branches, next_pc≠END_PC for 20 cycles -> stall sequence 0,1,1,1,1 repeating; exactly 4 issue cycles; cycle_count=20.
- Branch cut: jbr_taken pulsed in the 2nd stall cycle -> next cycle stall=0; the following 4 cycles stall=1.
- End of program: next_pc=32'h80088008 with jbr_taken=1 in the same cycle -> stall=0 for 2 cycles, done=1 on the 2nd edge and held; cycle_count frozen; later next_pc/jbr_taken changes have no effect.
- Mid-run reset: rst asserted during DRAIN -> core_rst=pc_rst=1, done=0, cycle_count=0 asynchronously; full sequence repeats after release.
- With PROC_RUN_TIMEOUT_EN and TIMEOUT_CYCLES=50, END_PC never seen -> timeout=1 and done=1 once cycle_count reaches 50; without the macro, timeout stays 0 and the block stays in RUN.
